// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning the HI/LO registers.
// Results are computed when an operation is accepted. They are then held in
// nextHI/nextLO until a fixed busy window expires, and only then written to HI/LO.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] next_hi;
  logic [DATA_W-1:0] next_lo;
  logic              wr_pending;

  logic              is_mul;
  logic              is_div;
  logic              start_ok;
  logic [63:0]       prod;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] q_mag;
  logic [DATA_W-1:0] r_mag;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;

  // Decode the operation class and whether a start is accepted this cycle.
  always_comb begin
    is_mul   = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
    is_div   = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
    start_ok = Start && (cnt == '0) && (is_mul || is_div);
  end

  // Result datapath. Signed division works on magnitudes, so 0x80000000 / -1
  // wraps to 0x80000000 and never overflows.
  always_comb begin
    prod    = '0;
    a_neg   = 1'b0;
    b_neg   = 1'b0;
    a_mag   = A;
    b_mag   = B;
    divisor = 32'd1;
    q_mag   = '0;
    r_mag   = '0;
    res_hi  = '0;
    res_lo  = '0;
    if (MDUOp == OP_MULT) begin
      prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    end else begin
      prod = {32'd0, A} * {32'd0, B};
    end
    if (MDUOp == OP_DIV) begin
      a_neg = A[31];
      b_neg = B[31];
    end
    a_mag   = a_neg ? (32'd0 - A) : A;
    b_mag   = b_neg ? (32'd0 - B) : B;
    divisor = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    if (is_div) begin
      res_lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      res_hi = a_neg ? (32'd0 - r_mag) : r_mag;
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  // HI/LO read-out for mfhi/mflo, with no bypass of pending results.
  always_comb begin
    Out = '0;
    if (MDUOp == OP_MFHI) begin
      Out = HI;
    end else if (MDUOp == OP_MFLO) begin
      Out = LO;
    end
  end

  // Operation sequencing: accept, count down, and commit to HI/LO. Also handles mthi/mtlo.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      HI         <= '0;
      LO         <= '0;
      cnt        <= '0;
      Busy       <= 1'b0;
      next_hi    <= '0;
      next_lo    <= '0;
      wr_pending <= 1'b0;
    end else if (cnt == '0) begin
      if (start_ok) begin
        next_hi    <= res_hi;
        next_lo    <= res_lo;
        wr_pending <= !(is_div && (B == '0));
        cnt        <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        Busy       <= 1'b1;
      end else if (!Start && (MDUOp == OP_MTHI)) begin
        HI <= A;
      end else if (!Start && (MDUOp == OP_MTLO)) begin
        LO <= A;
      end
    end else if (cnt == CNT_W'(1)) begin
      if (wr_pending) begin
        HI <= next_hi;
        LO <= next_lo;
      end
      cnt  <= '0;
      Busy <= 1'b0;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed and randomized checks of e_mdu against a timeline model of HI/LO.
module tb_e_mdu;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        Clk;
  logic        Reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] Out;
  logic [31:0] HI;
  logic [31:0] LO;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .Clk(Clk), .Reset(Reset), .A(A), .B(B), .MDUOp(MDUOp), .Start(Start),
    .Busy(Busy), .Out(Out), .HI(HI), .LO(LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural HI/LO plus the edge index at which the
  // in-flight operation commits (or -1 when nothing is in flight).
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] p_hi = 32'd0;
  logic [31:0] p_lo = 32'd0;
  bit          p_wr = 1'b0;
  int          edge_idx = 0;
  int          done_at  = -1;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Compute what the given operation should eventually leave in HI/LO.
  task automatic model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    p_wr = 1'b1;
    case (op)
      4'd1: begin q = sa * sb; p_hi = 32'(q >>> 32); p_lo = 32'(q); end
      4'd2: begin up = ua * ub; p_hi = 32'(up >> 32); p_lo = 32'(up); end
      4'd3: begin
        if (b == 32'd0) p_wr = 1'b0;
        else begin q = sa / sb; r = sa % sb; p_lo = 32'(q); p_hi = 32'(r); end
      end
      default: begin
        if (b == 32'd0) p_wr = 1'b0;
        else begin uq = ua / ub; ur = ua % ub; p_lo = 32'(uq); p_hi = 32'(ur); end
      end
    endcase
  endtask

  // One clock: drive inputs, check Out, apply the model at the edge, check state after it.
  task automatic step(input logic rst, input logic [3:0] op, input logic st,
                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_out;
    @(negedge Clk);
    Reset = rst; MDUOp = op; Start = st; A = a; B = b;
    #1;
    exp_out = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    check32("out", Out, exp_out);
    if (rst) begin
      m_hi = 32'd0; m_lo = 32'd0; done_at = -1;
    end else if (done_at == edge_idx) begin
      if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
      done_at = -1;
    end else if (done_at < 0) begin
      if (st && op >= 4'd1 && op <= 4'd4) begin
        model_result(op, a, b);
        done_at = edge_idx + ((op <= 4'd2) ? MULT_N : DIV_N);
      end else if (!st && op == 4'd7) m_hi = a;
      else if (!st && op == 4'd8) m_lo = a;
    end
    @(posedge Clk);
    #1;
    check32("busy", 32'(Busy), 32'(done_at > edge_idx));
    check32("hi", HI, m_hi);
    check32("lo", LO, m_lo);
    edge_idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
  endtask

  // Issue a start and idle until Busy drops, bounded; returns the observed busy length.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int blen);
    int guard;
    step(1'b0, op, 1'b1, a, b);
    blen = 0;
    guard = 0;
    while (Busy && guard < 40) begin
      blen++;
      guard++;
      idle(1);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int blen;
    Reset = 1'b1; MDUOp = 4'd0; Start = 1'b0; A = 32'd0; B = 32'd0;

    step(1'b1, 4'd0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 4'd0, 1'b0, 32'd0, 32'd0);
    check32("rst_busy", 32'(Busy), 32'd0);
    check32("rst_hi", HI, 32'd0);

    // mthi/mtlo and mfhi/mflo
    step(1'b0, 4'd7, 1'b0, 32'h1234_5678, 32'd0);
    step(1'b0, 4'd8, 1'b0, 32'h9ABC_DEF0, 32'd0);
    step(1'b0, 4'd5, 1'b0, 32'd0, 32'd0);
    check32("mfhi", Out, 32'h1234_5678);
    step(1'b0, 4'd6, 1'b0, 32'd0, 32'd0);
    check32("mflo", Out, 32'h9ABC_DEF0);

    // mult / multu
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, blen);
    check32("mult_len", 32'(blen), 32'd5);
    check32("mult_hi", HI, 32'hFFFF_FFFF);
    check32("mult_lo", LO, 32'hFFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, blen);
    check32("multu_len", 32'(blen), 32'd5);
    check32("multu_hi", HI, 32'h0000_0002);
    check32("multu_lo", LO, 32'hFFFF_FFFA);

    // div / divu
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, blen);
    check32("div_len", 32'(blen), 32'd10);
    check32("div_lo", LO, 32'hFFFF_FFFD);
    check32("div_hi", HI, 32'hFFFF_FFFF);
    run_op(4'd4, 32'd7, 32'd2, blen);
    check32("divu_lo", LO, 32'd3);
    check32("divu_hi", HI, 32'd1);

    // most-negative / -1
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, blen);
    check32("divovf_lo", LO, 32'h8000_0000);
    check32("divovf_hi", HI, 32'h0000_0000);

    // divide by zero leaves HI/LO intact
    step(1'b0, 4'd7, 1'b0, 32'h0000_AAAA, 32'd0);
    step(1'b0, 4'd8, 1'b0, 32'h0000_5555, 32'd0);
    run_op(4'd4, 32'd7, 32'd0, blen);
    check32("div0_len", 32'(blen), 32'd10);
    check32("div0_hi", HI, 32'h0000_AAAA);
    check32("div0_lo", LO, 32'h0000_5555);

    // start and mtlo while busy are ignored
    step(1'b0, 4'd1, 1'b1, 32'd6, 32'd7);
    step(1'b0, 4'd3, 1'b1, 32'd100, 32'd3);
    step(1'b0, 4'd8, 1'b0, 32'd1, 32'd0);
    idle(2);
    check32("ovl_busy4", 32'(Busy), 32'd1);
    idle(1);
    check32("ovl_busy_end", 32'(Busy), 32'd0);
    check32("ovl_hi", HI, 32'd0);
    check32("ovl_lo", LO, 32'd42);

    // reset mid-divide aborts it
    step(1'b0, 4'd3, 1'b1, 32'd100, 32'd7);
    idle(2);
    step(1'b1, 4'd0, 1'b0, 32'd0, 32'd0);
    check32("abort_busy", 32'(Busy), 32'd0);
    check32("abort_hi", HI, 32'd0);
    idle(12);
    check32("abort_lo_late", LO, 32'd0);
    run_op(4'd1, 32'd5, 32'hFFFF_FFFD, blen);
    check32("post_len", 32'(blen), 32'd5);
    check32("post_lo", LO, 32'hFFFF_FFF1);
    check32("post_hi", HI, 32'hFFFF_FFFF);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           rand_operand(), rand_operand());
    end
    idle(DIV_N + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
